btb_update_ctrl: RTL
====================

# btb_update_ctrl

Write-side scheduler for the 4-way branch target buffer. It accepts resolved-branch updates from the MEM stage, buffers taken branches in a small FIFO, and drains them into the BTB write port. Drains happen only in cycles where fetch is not performing a BTB lookup, with a starvation override. It also sequences a set-by-set invalidate sweep after reset and on flush requests, such as a pipeline flush or a self-modifying-code event.

## Interface

Reset is synchronous and active-low (`reset_n`), sampled on the rising edge of `clk`.

Parameters:
- `DEPTH`, 4, update FIFO entries (power of 2, ≥2)
- `NUM_SETS`, 8, BTB sets swept by an invalidate (power of 2)
- `STARVE_LIMIT`, 4, consecutive blocked cycles before a write is forced (≥1)

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  synchronous active-low reset
- `upd_valid`  in  1  MEM stage presents a resolved branch
- `upd_pc`  in  16  lc3b_word, branch PC
- `upd_target`  in  16  lc3b_word, resolved target
- `upd_taken`  in  1  branch was taken
- `upd_ready`  out  1  update accepted this cycle if `upd_valid`
- `flush_req`  in  1  request a full invalidate sweep
- `fetch_lookup`  in  1  fetch is using the BTB read port this cycle
- `btb_wb_enable`  out  1  write FIFO head into BTB this cycle
- `btb_wb_addr`  out  16  PC of head entry
- `btb_wb_target`  out  16  target of head entry
- `btb_inv_enable`  out  1  invalidate all ways of `btb_inv_index`
- `btb_inv_index`  out  log2(NUM_SETS)  set being invalidated
- `busy`  out  1  FSM in FLUSH or FIFO non-empty
- `count`  out  log2(DEPTH)+1  FIFO occupancy

## Operation

- FSM states are RUN and FLUSH.
  - Reset enters FLUSH with `inv_index`=0, `count`=0, starve counter=0.
  - FLUSH: `btb_inv_enable`=1 every cycle; `btb_inv_index` increments 0..NUM_SETS-1, one per cycle. The cycle after index NUM_SETS-1 the FSM is in RUN.
  - RUN → FLUSH when `flush_req`=1. FIFO is cleared at that edge; pending updates are dropped as stale. `inv_index` restarts at 0.
  - `flush_req` during FLUSH is ignored; the sweep is not restarted.
- `upd_ready` = RUN && count<DEPTH && !`flush_req` (combinational).
- Accept happens when `upd_valid && upd_ready`.
  - If `upd_taken`=1, push {pc,target}.
  - If `upd_taken`=0, the update is consumed and discarded; count is unchanged.
- Drain is combinational from the head:
  - `btb_wb_enable` = RUN && count>0 && (!`fetch_lookup` || starve), where starve = (starve_cnt == STARVE_LIMIT).
  - A write cycle pops the head.
  - `btb_wb_addr`/`btb_wb_target` equal the head entry whenever count>0, else 0.
- Starve counter:
  - Increments (saturating) in each RUN cycle with count>0, `fetch_lookup`=1, and no write.
  - Clears on any write cycle, when count=0, and in FLUSH.
- Push and pop in the same cycle: count unchanged; the pointers wrap modulo DEPTH.
- When full, `upd_ready` stays low even if a pop occurs that cycle; the push is retried next cycle.
- `btb_wb_enable` and `btb_inv_enable` are never high together.

## Timing

- Reset values: `upd_ready`=0, `btb_wb_enable`=0, `btb_wb_addr`=`btb_wb_target`=0, `btb_inv_enable`=1, `btb_inv_index`=0, `busy`=1, `count`=0.
- The post-reset sweep takes NUM_SETS cycles. `upd_ready` first goes high in cycle NUM_SETS after reset deasserts.
- Enqueue-to-write latency is 1 cycle minimum: an entry pushed at edge t can drive `btb_wb_enable` in the cycle after t.
- Under a continuously high `fetch_lookup`, the head is written in the (STARVE_LIMIT+1)th cycle it is at the head.
- If `flush_req` and `upd_valid` arrive in the same RUN cycle, the flush wins and the update is not accepted.
- `reset_n`=0 mid-sweep or mid-drain clears the FIFO and restarts the sweep at index 0.

## Test plan

- Reset, NUM_SETS=8: `btb_inv_index` steps 0..7 over 8 cycles with `btb_inv_enable`=1 and `upd_ready`=0; cycle 8 is RUN with `upd_ready`=1 and `busy`=0.
- Push taken {0x3000→0x3040} with `fetch_lookup`=0: the next cycle shows `btb_wb_enable`=1, addr 0x3000, target 0x3040; then count returns to 0.
- Push 4 taken updates with `fetch_lookup`=1: count=4 and `upd_ready`=0; the first write occurs on the 5th cycle at head. Drain order matches push order, each entry waiting 5 cycles.
- Not-taken update (0x3010, taken=0): accepted; count stays 0; no `btb_wb_enable`.
- With 3 entries queued, pulse `flush_req`: count→0, 8-cycle sweep, no write of the dropped entries. A second `flush_req` mid-sweep does not extend the sweep.
- Simultaneous push and pop at count=2 across pointer wrap (after 5 prior pushes): count stays 2; FIFO order is preserved.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_ctrl_if
//  Brief    : Update, drain and invalidate signals of the BTB write scheduler.
//  Revision : 1.0
// ============================================================================
interface btb_update_ctrl_if #(
    parameter int DEPTH    = 4,
    parameter int NUM_SETS = 8
);
    localparam int IW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          upd_valid;
    logic [15:0]   upd_pc;
    logic [15:0]   upd_target;
    logic          upd_taken;
    logic          upd_ready;
    logic          flush_req;
    logic          fetch_lookup;
    logic          btb_wb_enable;
    logic [15:0]   btb_wb_addr;
    logic [15:0]   btb_wb_target;
    logic          btb_inv_enable;
    logic [IW-1:0] btb_inv_index;
    logic          busy;
    logic [CW-1:0] count;

    // master: MEM/fetch side; slave: the update controller
    modport master (
        output upd_valid, upd_pc, upd_target, upd_taken, flush_req, fetch_lookup,
        input  upd_ready, btb_wb_enable, btb_wb_addr, btb_wb_target,
               btb_inv_enable, btb_inv_index, busy, count
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_taken, flush_req, fetch_lookup,
        output upd_ready, btb_wb_enable, btb_wb_addr, btb_wb_target,
               btb_inv_enable, btb_inv_index, busy, count
    );
endinterface
`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_ctrl
//  Brief    : Buffers taken-branch updates and drains them into the BTB write
//             port in fetch-idle cycles; sequences invalidate sweeps.
//  Revision : 1.0
// ============================================================================
module btb_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int NUM_SETS     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    btb_update_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [IW-1:0] c_last_set = IW'(NUM_SETS - 1);
    localparam logic [SW-1:0] c_starve   = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t        state_q,     state_d;
    logic [IW-1:0] inv_index_q, inv_index_d;
    logic [CW-1:0] count_q,     count_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [SW-1:0] starve_q,    starve_d;

    logic [15:0]   fifo_pc_q  [DEPTH];
    logic [15:0]   fifo_tgt_q [DEPTH];

    logic w_run;
    logic w_starve;
    logic w_ready;
    logic w_push;
    logic w_wb;

    always_comb begin
        w_run    = (state_q == ST_RUN);
        w_starve = (starve_q == c_starve);
        w_ready  = w_run && (count_q < c_depth) && !bus.flush_req;
        // not-taken updates are accepted but never occupy a slot
        w_push   = bus.upd_valid && w_ready && bus.upd_taken;
        w_wb     = w_run && (count_q != '0) && (!bus.fetch_lookup || w_starve);
    end

    always_comb begin
        state_d     = state_q;
        inv_index_d = inv_index_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        starve_d    = starve_q;
        case (state_q)
            ST_FLUSH: begin
                starve_d = '0;
                if (inv_index_q == c_last_set) begin
                    state_d     = ST_RUN;
                    inv_index_d = '0;
                end else begin
                    inv_index_d = inv_index_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.flush_req) begin
                    // queued updates may describe code that is about to change
                    state_d     = ST_FLUSH;
                    inv_index_d = '0;
                    count_d     = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    starve_d    = '0;
                end else begin
                    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (w_wb)   rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d = count_q + CW'(w_push) - CW'(w_wb);
                    if ((count_q == '0) || w_wb) begin
                        starve_d = '0;
                    end else if (!w_starve) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_FLUSH;
            inv_index_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            inv_index_q <= inv_index_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            starve_q    <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_pc_q[wr_ptr_q]  <= bus.upd_pc;
            fifo_tgt_q[wr_ptr_q] <= bus.upd_target;
        end
    end

    assign bus.upd_ready      = w_ready;
    assign bus.btb_wb_enable  = w_wb;
    assign bus.btb_wb_addr    = (count_q != '0) ? fifo_pc_q[rd_ptr_q]  : 16'h0000;
    assign bus.btb_wb_target  = (count_q != '0) ? fifo_tgt_q[rd_ptr_q] : 16'h0000;
    assign bus.btb_inv_enable = (state_q == ST_FLUSH);
    assign bus.btb_inv_index  = inv_index_q;
    assign bus.busy           = (state_q == ST_FLUSH) || (count_q != '0);
    assign bus.count          = count_q;

endmodule
`default_nettype wire
